butterfly_unit: RTL and testbench



---
 rtl/butterfly_unit.sv | 72 +++++++
 tb/tb_butterfly_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/butterfly_unit.sv
// rtl/butterfly_unit.sv - radix-2 complex butterfly A+B*W / A-B*W, Q1.15, one-cycle latency.
// Define BUTTERFLYUNIT_SAT_EN to saturate results instead of wrapping them.
module butterfly_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] A_t,
    input  logic [31:0] B_t,
    input  logic [31:0] W,
    output logic [31:0] A_f,
    output logic [31:0] B_f,
    output logic        out_valid
);

    logic signed [15:0] ar, ai, br, bi, wr, wi;
    logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [32:0] pr_sum, pi_sum;
    logic signed [17:0] pr, pi;
    logic signed [17:0] sum_re, sum_im, dif_re, dif_im;

    assign ar = A_t[31:16];
    assign ai = A_t[15:0];
    assign br = B_t[31:16];
    assign bi = B_t[15:0];
    assign wr = W[31:16];
    assign wi = W[15:0];

    assign p_rr = br * wr;
    assign p_ii = bi * wi;
    assign p_ri = br * wi;
    assign p_ir = bi * wr;

    assign pr_sum = $signed({p_rr[31], p_rr}) - $signed({p_ii[31], p_ii});
    assign pi_sum = $signed({p_ri[31], p_ri}) + $signed({p_ir[31], p_ir});

    // Floor scaling back to Q1.15; 18 bits cover the full +/-2^16 product range.
    assign pr = 18'(pr_sum >>> 15);
    assign pi = 18'(pi_sum >>> 15);

    assign sum_re = $signed({{2{ar[15]}}, ar}) + pr;
    assign sum_im = $signed({{2{ai[15]}}, ai}) + pi;
    assign dif_re = $signed({{2{ar[15]}}, ar}) - pr;
    assign dif_im = $signed({{2{ai[15]}}, ai}) - pi;

    function automatic logic [15:0] reduce(input logic signed [17:0] v);
`ifdef BUTTERFLYUNIT_SAT_EN
        if (v > 18'sd32767)
            reduce = 16'h7fff;
        else if (v < -18'sd32768)
            reduce = 16'h8000;
        else
            reduce = 16'(v);
`else
        reduce = 16'(v);
`endif
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A_f       <= '0;
            B_f       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                A_f <= {reduce(sum_re), reduce(sum_im)};
                B_f <= {reduce(dif_re), reduce(dif_im)};
            end
        end
    end

endmodule

// File: tb/tb_butterfly_unit.sv
// tb/tb_butterfly_unit.sv - directed and random scoreboard bench for butterfly_unit.
module tb_butterfly_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] A_t = '0;
    logic [31:0] B_t = '0;
    logic [31:0] W = '0;
    logic [31:0] A_f;
    logic [31:0] B_f;
    logic        out_valid;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } res_t;

    res_t sb[$];
    res_t last_res = '0;
    int   checks = 0;
    int   errors = 0;

    butterfly_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .A_t(A_t), .B_t(B_t), .W(W),
        .A_f(A_f), .B_f(B_f), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_reduce(input longint v);
`ifdef BUTTERFLYUNIT_SAT_EN
        if (v > 32767) return 16'h7fff;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    function automatic res_t ref_bfly(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w);
        longint ar, ai, br, bi, wr, wi, pr, pi;
        res_t r;
        ar = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
        wr = longint'($signed(w[31:16])); wi = longint'($signed(w[15:0]));
        pr = (br * wr - bi * wi) >>> 15;
        pi = (br * wi + bi * wr) >>> 15;
        r.a = {ref_reduce(ar + pr), ref_reduce(ai + pi)};
        r.b = {ref_reduce(ar - pr), ref_reduce(ai - pi)};
        return r;
    endfunction

    // One clock: drive at negedge, sample 1 time unit after the posedge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] w, input res_t exp);
        res_t got;
        @(negedge clk);
        in_valid = v; A_t = a; B_t = b; W = w;
        if (v) sb.push_back(exp);
        @(posedge clk);
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, v});
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                got = sb.pop_front();
                chk("A_f", A_f, got.a);
                chk("B_f", B_f, got.b);
                last_res = got;
            end
        end else begin
            chk("hold_A_f", A_f, last_res.a);
            chk("hold_B_f", B_f, last_res.b);
        end
    endtask

    initial begin
        res_t e;
        logic [31:0] ra, rb, rw;

        #2;
        chk("rst_A_f", A_f, 32'h0);
        chk("rst_B_f", B_f, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        e.a = 32'h0F9F_0000; e.b = 32'hF831_0000;
        cycle(1'b1, 32'h03E8_0000, 32'h0BB8_0000, 32'h7fff_0000, e);
        e.a = 32'h03E8_F448; e.b = 32'h03E8_0BB8;
        cycle(1'b1, 32'h03E8_0000, 32'h0BB8_0000, 32'h0000_8000, e);
`ifdef BUTTERFLYUNIT_SAT_EN
        e.a = 32'h7FFF_0000;
`else
        e.a = 32'hEA5F_0000;
`endif
        e.b = 32'h0001_0000;
        cycle(1'b1, 32'h7530_0000, 32'h7530_0000, 32'h7fff_0000, e);
`ifdef BUTTERFLYUNIT_SAT_EN
        e.a = 32'h0000_7FFF;
`else
        e.a = 32'h0000_8000;
`endif
        e.b = 32'h0000_8000;
        cycle(1'b1, 32'h0000_0000, 32'h8000_0000, 32'h0000_8000, e);

        // Single pulse then idle cycles with changing operands: outputs must hold.
        e.a = 32'h0F9F_0000; e.b = 32'hF831_0000;
        cycle(1'b1, 32'h03E8_0000, 32'h0BB8_0000, 32'h7fff_0000, e);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, $urandom, $urandom, $urandom, '0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom; rb = $urandom; rw = $urandom;
            cycle(1'b1, ra, rb, rw, ref_bfly(ra, rb, rw));
        end
        cycle(1'b0, 32'h0, 32'h0, 32'h0, '0);

        // Reset asserted between edges clears outputs without a clock.
        ra = $urandom; rb = $urandom; rw = $urandom;
        cycle(1'b1, ra, rb, rw, ref_bfly(ra, rb, rw));
        #2;
        in_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk("async_A_f", A_f, 32'h0);
        chk("async_B_f", B_f, 32'h0);
        chk("async_out_valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_wins_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_wins_A_f", A_f, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        last_res = '0;
        cycle(1'b0, 32'h1234_5678, 32'h1111_2222, 32'h7fff_0000, '0);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, '0);

        e.a = 32'h03E8_F448; e.b = 32'h03E8_0BB8;
        cycle(1'b1, 32'h03E8_0000, 32'h0BB8_0000, 32'h0000_8000, e);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, '0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
